// File: rtl/lht_update_scheduler.sv
`timescale 1ns/1ps
// lht_update_scheduler
//
// Sequencing controller for the single-port local history table (LHT) RAM of
// the tournament predictor. Resolved branch outcomes are queued in a small
// FIFO. Each queued outcome is applied to the RAM as a read-modify-write:
// the history is shifted right and the outcome enters the MSB. Fetch-time
// lookups share the RAM port and normally win arbitration. A starvation
// counter forces an update through after STARVE_MAX consecutive lookup wins.
// After reset or flush, the whole table is swept to zero.
//
// Optional feature macro: LHT_BYPASS_EN
//   defined   : in the write cycle, a lookup to the index being written is
//               granted. It receives the new value one cycle later from a
//               register, not from the RAM.
//   undefined : no lookup is granted in the write cycle.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   flush               restart the clear sweep and drop all queued updates
//   upd_valid/ready     resolved-branch record handshake (upd_pc, upd_taken)
//   lk_valid, lk_pc     prediction lookup request
//   lk_grant            lookup accepted this cycle
//   lk_hist_valid/hist  lookup result, one cycle after the grant (0 if idle)
//   busy                clear sweep in progress
//   ram_en/we/addr/wdata/rdata  single-port RAM, one-cycle read latency
module lht_update_scheduler #(
  parameter int IDX_W      = 10,
  parameter int HIST_W     = 10,  // must be >= 2
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter int STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic              lk_valid,
  input  logic [31:0]       lk_pc,
  output logic              lk_grant,
  output logic              lk_hist_valid,
  output logic [HIST_W-1:0] lk_hist,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [IDX_W-1:0]  ram_addr,
  output logic [HIST_W-1:0] ram_wdata,
  input  logic [HIST_W-1:0] ram_rdata
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0]    FIFO_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {INIT, IDLE, WR} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    sweep_addr_reg, sweep_addr_next;
  logic [STARVE_W-1:0] starve_reg, starve_next;

  // Pending-update queue: only the table index and outcome are kept.
  logic [IDX_W-1:0]    fifo_idx   [FIFO_DEPTH];
  logic                fifo_taken [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;

  // Lookup result sources: RAM read data or the registered bypass value.
  logic                lk_ram_pend_reg, lk_ram_pend_next;
  logic                byp_pend_reg, byp_pend_next;
  logic [HIST_W-1:0]   byp_data_reg, byp_data_next;

  logic                fifo_empty, fifo_full, push, pop;
  logic [IDX_W-1:0]    head_idx, lk_idx;
  logic                head_taken;
  logic [HIST_W-1:0]   shifted;

  // Only the low index bits of the PCs select a table entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[31:IDX_W], lk_pc[31:IDX_W]};

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FIFO_FULL);
  assign head_idx   = fifo_idx[rd_ptr_reg];
  assign head_taken = fifo_taken[rd_ptr_reg];
  assign lk_idx     = lk_pc[IDX_W-1:0];
  assign shifted    = {head_taken, ram_rdata[HIST_W-1:1]};

  // A flush empties the queue at the next edge, so a record offered in the
  // same cycle would be lost; refuse it instead.
  assign upd_ready = !fifo_full && (state_reg != INIT) && !flush;
  assign push      = upd_valid && upd_ready;

  assign lk_hist_valid = lk_ram_pend_reg || byp_pend_reg;
  assign lk_hist       = byp_pend_reg    ? byp_data_reg :
                         lk_ram_pend_reg ? ram_rdata    : '0;

  always_comb begin
    state_next       = state_reg;
    sweep_addr_next  = sweep_addr_reg;
    starve_next      = starve_reg;
    lk_ram_pend_next = 1'b0;
    byp_pend_next    = 1'b0;
    byp_data_next    = '0;
    busy             = 1'b0;
    ram_en           = 1'b0;
    ram_we           = 1'b0;
    ram_addr         = '0;
    ram_wdata        = '0;
    lk_grant         = 1'b0;
    pop              = 1'b0;

    case (state_reg)
      INIT: begin
        busy            = 1'b1;
        ram_en          = 1'b1;
        ram_we          = 1'b1;
        ram_addr        = sweep_addr_reg;
        sweep_addr_next = sweep_addr_reg + 1'b1;
        if (sweep_addr_reg == '1) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (!flush) begin
          if (!fifo_empty && (!lk_valid || starve_reg == STARVE_LIM)) begin
            // Update read: data returns in WR.
            ram_en      = 1'b1;
            ram_addr    = head_idx;
            starve_next = '0;
            state_next  = WR;
          end else if (lk_valid) begin
            ram_en           = 1'b1;
            ram_addr         = lk_idx;
            lk_grant         = 1'b1;
            lk_ram_pend_next = 1'b1;
            if (fifo_empty) begin
              starve_next = '0;
            end else if (starve_reg != STARVE_LIM) begin
              starve_next = starve_reg + 1'b1;
            end
          end else if (fifo_empty) begin
            starve_next = '0;
          end
        end
      end

      WR: begin
        // Under flush the write is abandoned and the entry is dropped with
        // the rest of the queue.
        if (!flush) begin
          ram_en     = 1'b1;
          ram_we     = 1'b1;
          ram_addr   = head_idx;
          ram_wdata  = shifted;
          pop        = 1'b1;
          state_next = IDLE;
`ifdef LHT_BYPASS_EN
          if (lk_valid && lk_idx == head_idx) begin
            lk_grant      = 1'b1;
            byp_pend_next = 1'b1;
            byp_data_next = shifted;
          end
`endif
        end
      end

      default: begin
        state_next = INIT;
      end
    endcase

    if (flush) begin
      state_next      = INIT;
      sweep_addr_next = '0;
      starve_next     = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= INIT;
      sweep_addr_reg  <= '0;
      starve_reg      <= '0;
      lk_ram_pend_reg <= 1'b0;
      byp_pend_reg    <= 1'b0;
      byp_data_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      sweep_addr_reg  <= sweep_addr_next;
      starve_reg      <= starve_next;
      lk_ram_pend_reg <= lk_ram_pend_next;
      byp_pend_reg    <= byp_pend_next;
      byp_data_reg    <= byp_data_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Queue storage needs no reset: entries are only read when counted.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_idx[wr_ptr_reg]   <= upd_pc[IDX_W-1:0];
      fifo_taken[wr_ptr_reg] <= upd_taken;
    end
  end

endmodule

// File: tb/tb_lht_update_scheduler.sv
`timescale 1ns/1ps
module tb_lht_update_scheduler;

  localparam int IDX_W      = 10;
  localparam int HIST_W     = 10;
  localparam int DEPTH      = 1 << IDX_W;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 8;
`ifdef LHT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset, flush;
  logic              upd_valid, upd_ready, upd_taken;
  logic [31:0]       upd_pc, lk_pc;
  logic              lk_valid, lk_grant, lk_hist_valid;
  logic [HIST_W-1:0] lk_hist;
  logic              busy, ram_en, ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [HIST_W-1:0] ram_wdata;
  logic [HIST_W-1:0] ram_rdata = '0;

  always #5 clock = ~clock;

  lht_update_scheduler #(
    .IDX_W(IDX_W), .HIST_W(HIST_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_grant(lk_grant),
    .lk_hist_valid(lk_hist_valid), .lk_hist(lk_hist), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM with registered read.
  logic [HIST_W-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Committed history per index, queue of accepted-but-unwritten outcomes,
  // sweep progress, and the starvation count of consecutive lookup wins.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_t;

  logic [HIST_W-1:0] committed [DEPTH];
  upd_t              q[$];
  bit                in_init = 1'b1;
  int                sweep = 0;
  int                starve = 0;
  bit                exp_wr_now = 1'b0;
  bit                lk_exp_valid = 1'b0;
  logic [HIST_W-1:0] lk_exp_data = '0;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      check("reset_busy", busy, 1);
      check("reset_en_we", {ram_en, ram_we}, 2'b11);
      check("reset_addr", ram_addr, 0);
      check("reset_lkv", lk_hist_valid, 0);
      in_init = 1'b1; sweep = 0; q.delete(); starve = 0;
      exp_wr_now = 1'b0; lk_exp_valid = 1'b0;
      foreach (committed[i]) committed[i] = '0;
    end else begin : model_step
      bit                new_lk_valid;
      logic [HIST_W-1:0] new_lk_data, exp_val;
      logic [IDX_W-1:0]  lidx;
      bit                exp_ready, exp_g;
      new_lk_valid = 1'b0;
      new_lk_data  = '0;
      lidx         = lk_pc[IDX_W-1:0];

      check("lk_hist_valid", lk_hist_valid, lk_exp_valid);
      check("lk_hist", lk_hist, lk_exp_valid ? lk_exp_data : '0);

      exp_ready = !in_init && (q.size() < FIFO_DEPTH) && !flush;
      check("upd_ready", upd_ready, exp_ready);
      check("busy", busy, in_init);

      if (in_init) begin
        check("sweep_en_we", {ram_en, ram_we}, 2'b11);
        check("sweep_addr", ram_addr, sweep);
        check("sweep_wdata", ram_wdata, 0);
        check("sweep_grant", lk_grant, 0);
        sweep++;
        if (sweep == DEPTH) in_init = 1'b0;
      end else if (exp_wr_now) begin
        exp_wr_now = 1'b0;
        exp_val = {q[0].taken, committed[q[0].idx][HIST_W-1:1]};
        if (flush) begin
          check("flush_wr_access", {ram_en, ram_we, lk_grant}, 3'b000);
        end else begin
          check("wr_en_we", {ram_en, ram_we}, 2'b11);
          check("wr_addr", ram_addr, q[0].idx);
          check("wr_data", ram_wdata, exp_val);
          exp_g = BYP && lk_valid && (lidx == q[0].idx);
          check("wr_grant", lk_grant, exp_g);
          if (exp_g) begin
            new_lk_valid = 1'b1;
            new_lk_data  = exp_val;
          end
          committed[q[0].idx] = exp_val;
          void'(q.pop_front());
        end
      end else begin
        if (flush) begin
          check("flush_idle_access", {ram_en, ram_we, lk_grant}, 3'b000);
        end else if (q.size() > 0 && (!lk_valid || starve == STARVE_MAX)) begin
          check("upd_rd_access", {ram_en, ram_we, lk_grant}, 3'b100);
          check("upd_rd_addr", ram_addr, q[0].idx);
          exp_wr_now = 1'b1;
          starve = 0;
        end else if (lk_valid) begin
          check("lk_access", {ram_en, ram_we, lk_grant}, 3'b101);
          check("lk_addr", ram_addr, lidx);
          new_lk_valid = 1'b1;
          new_lk_data  = committed[lidx];
          starve = (q.size() > 0) ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
        end else begin
          check("idle_access", {ram_en, ram_we, lk_grant}, 3'b000);
          if (q.size() == 0) starve = 0;
        end
      end

      if (upd_valid && exp_ready) q.push_back('{idx: upd_pc[IDX_W-1:0], taken: upd_taken});

      if (flush) begin
        in_init = 1'b1; sweep = 0; q.delete(); starve = 0; exp_wr_now = 1'b0;
        foreach (committed[i]) committed[i] = '0;
      end
      lk_exp_valid = new_lk_valid;
      lk_exp_data  = new_lk_data;
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic wait_sweep(output int n);
    n = 0;
    for (int i = 0; i < DEPTH + 50; i++) begin
      @(negedge clock);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic push_one(input logic [31:0] pc, input logic tk);
    @(posedge clock); #1;
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk;
    @(posedge clock); #1;
    upd_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0]       pc;
    logic              taken;
    logic [IDX_W-1:0]  exp_addr;
    logic [HIST_W-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    int n, c0, grants, accepted;
    bit found, acc, checked4;
    reset = 1'b1; flush = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    lk_valid = 1'b0; lk_pc = '0;

    vecs[0] = '{32'd1234, 1'b1, 10'd210, 10'h200};
    vecs[1] = '{32'd1234, 1'b0, 10'd210, 10'h100};
    vecs[2] = '{32'd1234, 1'b1, 10'd210, 10'h280};
    vecs[3] = '{32'd5,    1'b1, 10'd5,   10'h200};
    vecs[4] = '{32'd210,  1'b1, 10'd210, 10'h340};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    wait_sweep(n);
    check("sweep_len", n, DEPTH);
    check("post_sweep_busy", busy, 0);
    check("post_sweep_ready", upd_ready, 1);

    // Table-driven read-modify-write sequence, no lookups.
    for (int v = 0; v < 5; v++) begin
      @(posedge clock); #1;
      upd_valid = 1'b1; upd_pc = vecs[v].pc; upd_taken = vecs[v].taken;
      c0 = cyc;
      @(posedge clock); #1;
      upd_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clock);
        if (ram_we && !busy) found = 1'b1;
      end
      check("vec_write_seen", found, 1);
      check("vec_addr", ram_addr, vecs[v].exp_addr);
      check("vec_wdata", ram_wdata, vecs[v].exp_wdata);
      check("vec_latency", cyc - c0, 2);
    end

    // Starvation: one pending update against a continuous lookup stream.
    @(posedge clock); #1;
    lk_valid = 1'b1; lk_pc = 32'h300;
    upd_valid = 1'b1; upd_pc = 32'd77; upd_taken = 1'b1;
    @(posedge clock); #1;
    upd_valid = 1'b0;
    grants = 0; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (ram_en && !ram_we && !lk_grant) found = 1'b1;
      else if (lk_grant) grants++;
    end
    check("starve_upd_read", found, 1);
    check("starve_grants", grants, STARVE_MAX);
    @(negedge clock);
    check("starve_wr_grant", lk_grant, 0);
    check("starve_wr_we", ram_we, 1);
    @(negedge clock);
    check("starve_resume_grant", lk_grant, 1);

    // Five records offered while lookups stay high: back-pressure, no drops.
    @(posedge clock); #1;
    lk_pc = 32'h3F0;
    accepted = 0; checked4 = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'd100; upd_taken = 1'b0;
    for (int i = 0; i < 100 && accepted < 5; i++) begin
      @(negedge clock);
      acc = upd_ready;
      if (accepted == 4 && !checked4) begin
        check("ready_after_4th", upd_ready, 0);
        checked4 = 1'b1;
      end
      @(posedge clock); #1;
      if (acc) begin
        accepted++;
        upd_pc = 32'd100 + 32'(accepted);
        upd_taken = accepted[0];
      end
    end
    upd_valid = 1'b0;
    check("five_accepted", accepted, 5);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
    check("five_drained", q.size(), 0);
    @(posedge clock); #1;
    lk_valid = 1'b0;

    // Flush during WR: no write, sweep restarts, queue empty afterwards.
    push_one(32'd1234, 1'b1);
    @(posedge clock); #1;            // now in the write cycle
    flush = 1'b1;
    @(negedge clock);
    check("flush_no_write", ram_we, 0);
    @(posedge clock); #1;
    flush = 1'b0;
    wait_sweep(n);
    check("flush_sweep_len", n, DEPTH);
    repeat (5) begin
      @(negedge clock);
      check("flush_fifo_empty", ram_en, 0);
    end

    // Lookup to the entry being written (210: 0x200 -> 0x300).
    push_one(32'd1234, 1'b1);
    for (int i = 0; i < 10; i++) @(negedge clock);
    push_one(32'd1234, 1'b1);
    @(posedge clock); #1;            // write cycle
    lk_valid = 1'b1; lk_pc = 32'd210;
    @(negedge clock);
    check("byp_wdata", ram_wdata, 10'h300);
`ifdef LHT_BYPASS_EN
    check("byp_grant", lk_grant, 1);
    @(posedge clock); #1;
    lk_valid = 1'b0;
    @(negedge clock);
    check("byp_hist_valid", lk_hist_valid, 1);
    check("byp_hist", lk_hist, 10'h300);
`else
    check("nobyp_grant", lk_grant, 0);
    @(posedge clock); #1;
    lk_valid = 1'b0;
    @(negedge clock);
`endif

    // Asynchronous reset in the middle of a write.
    push_one(32'd5, 1'b1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("areset_busy", busy, 1);
    check("areset_addr", ram_addr, 0);
    check("areset_we", ram_we, 1);
    check("areset_ready", upd_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    wait_sweep(n);
    check("areset_sweep_len", n, DEPTH);

    // Randomized traffic over a few indices so updates and lookups collide.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      upd_valid = ($urandom_range(0, 99) < 40);
      upd_pc    = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 7));
      upd_taken = 1'($urandom_range(0, 1));
      lk_valid  = ($urandom_range(0, 99) < 60);
      lk_pc     = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 7));
    end
    @(posedge clock); #1;
    upd_valid = 1'b0; lk_valid = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clock);
    check("random_drained", q.size(), 0);
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
